ray_lane_dispatcher: RTL and testbench

RAY_LANE_DISPATCHER -- requirements
Module: ray_lane_dispatcher

---
 rtl/ray_lane_dispatcher.sv | 198 +++++++++++++++++++
 tb/tb_ray_lane_dispatcher.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ray_lane_dispatcher.sv
// Round-robin ray dispatcher: fans a ray stream out to NUM_LANES DDA lanes and
// re-serialises lane results in column order. Optional stall stats: RAY_LANE_DISPATCHER_STATS_EN.
module ray_lane_dispatcher #(
    parameter int NUM_LANES = 4,
    parameter int IN_W      = 64,
    parameter int OUT_W     = 39,
    parameter int NUM_COLS  = 320
) (
    input  logic                       pixel_clk_in,
    input  logic                       rst_in,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    input  logic [IN_W-1:0]            s_tdata,
    input  logic                       s_tlast,
    output logic [NUM_LANES-1:0]       lane_tvalid_out,
    input  logic [NUM_LANES-1:0]       lane_tready_in,
    output logic [NUM_LANES*IN_W-1:0]  lane_tdata_out,
    input  logic [NUM_LANES-1:0]       res_tvalid_in,
    output logic [NUM_LANES-1:0]       res_tready_out,
    input  logic [NUM_LANES*OUT_W-1:0] res_tdata_in,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [OUT_W-1:0]           m_tdata,
    output logic                       m_tlast,
    output logic [15:0]                in_flight_out,
    output logic                       frame_err_out
`ifdef RAY_LANE_DISPATCHER_STATS_EN
    ,
    output logic [31:0]                stall_cycles_out,
    output logic [31:0]                last_frame_stalls_out
`endif
);

    localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(NUM_LANES - 1);
    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(NUM_COLS - 1);

    logic [PTR_W-1:0] dp_q, dp_d;
    logic [PTR_W-1:0] cp_q, cp_d;
    logic [COL_W-1:0] ic_q, ic_d;
    logic [COL_W-1:0] oc_q, oc_d;
    logic [15:0]      flight_q, flight_d;
    logic             err_q, err_d;
    logic             mv_q, mv_d;
    logic [OUT_W-1:0] md_q, md_d;

    logic             lane_rdy_sel;
    logic             res_vld_sel;
    logic [OUT_W-1:0] res_dat_sel;
    logic             s_acc;
    logic             load_en;
    logic             take;
    logic             m_done;

    function automatic logic [PTR_W-1:0] adv_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_LANE) ? '0 : p + PTR_W'(1);
    endfunction

    // Lane select muxes: dispatch side follows dp, collect side follows cp.
    always_comb begin
        lane_rdy_sel = 1'b0;
        res_vld_sel  = 1'b0;
        res_dat_sel  = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (dp_q == PTR_W'(i)) begin
                lane_rdy_sel = lane_tready_in[i];
            end
            if (cp_q == PTR_W'(i)) begin
                res_vld_sel = res_tvalid_in[i];
                res_dat_sel = res_tdata_in[i*OUT_W +: OUT_W];
            end
        end
    end

    always_comb begin
        s_tready = !rst_in && lane_rdy_sel;
        s_acc    = s_tvalid && s_tready;
        load_en  = !rst_in && (!mv_q || m_tready);
        take     = load_en && res_vld_sel;
        m_done   = mv_q && m_tready;
    end

    always_comb begin
        lane_tvalid_out = '0;
        res_tready_out  = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            lane_tvalid_out[i] = !rst_in && s_tvalid && (dp_q == PTR_W'(i));
            res_tready_out[i]  = load_en && (cp_q == PTR_W'(i));
        end
    end

    assign lane_tdata_out = {NUM_LANES{s_tdata}};

    always_comb begin
        dp_d     = dp_q;
        cp_d     = cp_q;
        ic_d     = ic_q;
        oc_d     = oc_q;
        flight_d = flight_q;
        err_d    = err_q;
        mv_d     = mv_q;
        md_d     = md_q;

        // A premature or missing s_tlast flags the error; s_tlast always restarts the column count.
        if (s_acc) begin
            dp_d = adv_ptr(dp_q);
            if (s_tlast) begin
                if (ic_q != LAST_COL) begin
                    err_d = 1'b1;
                end
                ic_d = '0;
            end else begin
                if (ic_q == LAST_COL) begin
                    err_d = 1'b1;
                    ic_d  = '0;
                end else begin
                    ic_d = ic_q + COL_W'(1);
                end
            end
        end

        if (load_en) begin
            mv_d = take;
        end
        if (take) begin
            cp_d = adv_ptr(cp_q);
            md_d = res_dat_sel;
        end

        // oc tracks the column of the beat currently held in the output register.
        if (m_done) begin
            oc_d = (oc_q == LAST_COL) ? '0 : oc_q + COL_W'(1);
        end

        if (s_acc && !m_done && (flight_q != 16'hFFFF)) begin
            flight_d = flight_q + 16'd1;
        end else if (m_done && !s_acc && (flight_q != 16'h0000)) begin
            flight_d = flight_q - 16'd1;
        end
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            dp_q     <= '0;
            cp_q     <= '0;
            ic_q     <= '0;
            oc_q     <= '0;
            flight_q <= '0;
            err_q    <= 1'b0;
            mv_q     <= 1'b0;
            md_q     <= '0;
        end else begin
            dp_q     <= dp_d;
            cp_q     <= cp_d;
            ic_q     <= ic_d;
            oc_q     <= oc_d;
            flight_q <= flight_d;
            err_q    <= err_d;
            mv_q     <= mv_d;
            md_q     <= md_d;
        end
    end

    assign m_tvalid      = mv_q;
    assign m_tdata       = md_q;
    assign m_tlast       = mv_q && (oc_q == LAST_COL);
    assign in_flight_out = flight_q;
    assign frame_err_out = err_q;

`ifdef RAY_LANE_DISPATCHER_STATS_EN
    logic [31:0] stall_q;
    logic [31:0] lfs_q;
    logic        stall_now;
    logic        frame_end;

    always_comb begin
        stall_now = s_tvalid && !s_tready;
        frame_end = m_done && m_tlast;
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            stall_q <= '0;
            lfs_q   <= '0;
        end else if (frame_end) begin
            lfs_q   <= stall_q;
            stall_q <= '0;
        end else if (stall_now && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles_out      = stall_q;
    assign last_frame_stalls_out = lfs_q;
`endif

endmodule

// File: tb/tb_ray_lane_dispatcher.sv
// Directed bench for ray_lane_dispatcher (NUM_LANES=4, NUM_COLS=320).
module tb_ray_lane_dispatcher;

    localparam int NL = 4;
    localparam int IW = 64;
    localparam int OW = 39;
    localparam int NC = 320;

    logic              clk;
    logic              rst;
    logic              s_tvalid;
    logic              s_tready;
    logic [IW-1:0]     s_tdata;
    logic              s_tlast;
    logic [NL-1:0]     lane_tvalid;
    logic [NL-1:0]     lane_tready;
    logic [NL*IW-1:0]  lane_tdata;
    logic [NL-1:0]     res_tvalid;
    logic [NL-1:0]     res_tready;
    logic [NL*OW-1:0]  res_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic [OW-1:0]     m_tdata;
    logic              m_tlast;
    logic [15:0]       in_flight;
    logic              frame_err;

    int vectors    = 0;
    int miscompares = 0;

    ray_lane_dispatcher #(
        .NUM_LANES(NL),
        .IN_W     (IW),
        .OUT_W    (OW),
        .NUM_COLS (NC)
    ) dut (
        .pixel_clk_in   (clk),
        .rst_in         (rst),
        .s_tvalid       (s_tvalid),
        .s_tready       (s_tready),
        .s_tdata        (s_tdata),
        .s_tlast        (s_tlast),
        .lane_tvalid_out(lane_tvalid),
        .lane_tready_in (lane_tready),
        .lane_tdata_out (lane_tdata),
        .res_tvalid_in  (res_tvalid),
        .res_tready_out (res_tready),
        .res_tdata_in   (res_tdata),
        .m_tvalid       (m_tvalid),
        .m_tready       (m_tready),
        .m_tdata        (m_tdata),
        .m_tlast        (m_tlast),
        .in_flight_out  (in_flight),
        .frame_err_out  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_res(input int lane, input logic [OW-1:0] val);
        res_tdata[lane*OW +: OW] = val;
    endtask

    logic [OW-1:0] lane_q [NL][$];

    initial begin
        int sent;
        int got;
        int cyc;
        logic [IW-1:0] slice;

        rst         = 1'b1;
        s_tvalid    = 1'b0;
        s_tdata     = '0;
        s_tlast     = 1'b0;
        lane_tready = '1;
        res_tvalid  = '0;
        res_tdata   = '0;
        m_tready    = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_in_flight", in_flight, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_lane_tvalid", lane_tvalid, 0);
        chk("rst_res_tready", res_tready, 0);
        rst = 1'b0;
        tick();

        // Eight rays round-robin across four ready lanes
        for (int k = 0; k < 8; k++) begin
            s_tvalid = 1'b1;
            s_tdata  = 64'hABC0 + 64'(k);
            #1;
            chk("disp_onehot", lane_tvalid, 64'(1) << (k % 4));
            chk("disp_s_tready", s_tready, 1);
            slice = lane_tdata[(k % 4)*IW +: IW];
            chk("disp_bcast", slice, 64'hABC0 + 64'(k));
            tick();
        end
        s_tvalid = 1'b0;
        #1;
        chk("disp_idle", lane_tvalid, 0);
        chk("disp_in_flight", in_flight, 8);

        // Lane 2 late, lane 3 early: column order must be kept
        m_tready   = 1'b1;
        res_tvalid = 4'b1011;
        for (int i = 0; i < NL; i++) set_res(i, 39'h100 + 39'(i));
        #1;
        chk("ord_rdy0", res_tready, 4'b0001);
        tick();
        res_tvalid = 4'b1010;
        #1;
        chk("ord_col0_v", m_tvalid, 1);
        chk("ord_col0", m_tdata, 39'h100);
        chk("ord_rdy1", res_tready, 4'b0010);
        chk("ord_flight8", in_flight, 8);
        tick();
        res_tvalid = 4'b1000;
        #1;
        chk("ord_col1", m_tdata, 39'h101);
        chk("ord_flight7", in_flight, 7);
        chk("ord_rdy2", res_tready, 4'b0100);
        tick();
        for (int w = 0; w < 10; w++) begin
            chk("ord_wait_v", m_tvalid, 0);
            chk("ord_wait_rdy", res_tready, 4'b0100);
            tick();
        end
        chk("ord_flight6", in_flight, 6);
        res_tvalid = 4'b1100;
        #1;
        tick();
        res_tvalid = 4'b1000;
        #1;
        chk("ord_col2", m_tdata, 39'h102);
        chk("ord_rdy3", res_tready, 4'b1000);
        tick();
        res_tvalid = 4'b0000;
        #1;
        chk("ord_col3", m_tdata, 39'h103);
        chk("ord_flight5", in_flight, 5);

        // Output backpressure: register full, no lane may be popped
        m_tready = 1'b0;
        tick();
        res_tvalid = 4'b1111;
        for (int i = 0; i < NL; i++) set_res(i, 39'h104 + 39'(i));
        for (int w = 0; w < 5; w++) begin
            #1;
            chk("bp_hold_v", m_tvalid, 1);
            chk("bp_hold_d", m_tdata, 39'h103);
            chk("bp_no_rdy", res_tready, 0);
            tick();
        end
        m_tready = 1'b1;
        #1;
        chk("bp_resume_rdy", res_tready, 4'b0001);
        for (int k = 0; k < 4; k++) begin
            tick();
            res_tvalid[k] = 1'b0;
            #1;
            chk("bp_resume_d", m_tdata, 39'h104 + 39'(k));
            chk("bp_resume_flt", in_flight, 64'(4 - k));
        end
        tick();
        chk("bp_drain_v", m_tvalid, 0);
        chk("bp_drain_flt", in_flight, 0);
        chk("bp_no_tlast", m_tlast, 0);

        // Reset with three rays in flight and a held output beat
        for (int k = 0; k < 3; k++) begin
            s_tvalid = 1'b1;
            s_tdata  = 64'hA0 + 64'(k);
            tick();
        end
        s_tvalid   = 1'b0;
        m_tready   = 1'b0;
        res_tvalid = 4'b0001;
        set_res(0, 39'h1A0);
        tick();
        chk("mid_v", m_tvalid, 1);
        chk("mid_flt", in_flight, 3);
        rst        = 1'b1;
        res_tvalid = 4'b1111;
        s_tvalid   = 1'b1;
        tick();
        chk("mrst_v", m_tvalid, 0);
        chk("mrst_d", m_tdata, 0);
        chk("mrst_flt", in_flight, 0);
        chk("mrst_lane_v", lane_tvalid, 0);
        chk("mrst_res_rdy", res_tready, 0);
        chk("mrst_s_rdy", s_tready, 0);
        rst        = 1'b0;
        res_tvalid = '0;
        m_tready   = 1'b1;
        #1;
        chk("mrst_first_lane", lane_tvalid, 4'b0001);
        s_tvalid = 1'b0;
        tick();

        // Two full frames, streaming, with a simple in-order lane model
        sent = 0;
        got  = 0;
        for (cyc = 0; cyc < 2000 && (sent < 2*NC || got < 2*NC); cyc++) begin
            s_tvalid = (sent < 2*NC);
            s_tdata  = 64'(sent);
            s_tlast  = ((sent % NC) == NC - 1);
            for (int i = 0; i < NL; i++) begin
                res_tvalid[i] = (lane_q[i].size() > 0);
                set_res(i, (lane_q[i].size() > 0) ? lane_q[i][0] : '0);
            end
            #2;
            if (m_tvalid && m_tready) begin
                chk("frm_data", m_tdata, 64'(got));
                chk("frm_tlast", m_tlast, ((got % NC) == NC - 1));
                got++;
            end
            if (s_tvalid && s_tready) begin
                chk("frm_lane", lane_tvalid, 64'(1) << (sent % NL));
                lane_q[sent % NL].push_back(OW'(sent));
                sent++;
            end
            for (int i = 0; i < NL; i++) begin
                if (res_tvalid[i] && res_tready[i]) void'(lane_q[i].pop_front());
            end
            tick();
        end
        chk("frm_got_all", got, 2*NC);
        s_tvalid   = 1'b0;
        s_tlast    = 1'b0;
        res_tvalid = '0;
        tick();
        chk("frm_err_clean", frame_err, 0);
        chk("frm_flt_zero", in_flight, 0);

        // Early s_tlast on ray 100 sets a sticky frame error
        lane_tready = '0;
        s_tvalid    = 1'b1;
        #1;
        chk("lane_bp_s_rdy", s_tready, 0);
        chk("lane_bp_tvalid", lane_tvalid, 4'b0001);
        lane_tready = '1;
        for (int k = 0; k < 100; k++) begin
            s_tdata = 64'(k);
            s_tlast = 1'b0;
            tick();
        end
        chk("err_before", frame_err, 0);
        s_tlast = 1'b1;
        tick();
        chk("err_set", frame_err, 1);
        for (int k = 0; k < NC; k++) begin
            s_tlast = (k == NC - 1);
            tick();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        tick();
        chk("err_sticky", frame_err, 1);
        chk("err_flt", in_flight, 421);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("err_cleared", frame_err, 0);
        chk("err_flt_cleared", in_flight, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
